// File: rtl/dice_roller_if.sv
// Roll-control and result signals shared between the dice roller and its user.
// master drives the button and hold mask; slave is the roller itself.
interface dice_roller_if #(
  parameter int unsigned FACES = 6,
  parameter int unsigned NDICE = 2
);
  localparam int unsigned W  = $clog2(FACES + 1);
  localparam int unsigned SW = $clog2(NDICE * FACES + 1);

  logic                 button;
  logic [NDICE-1:0]     hold;
  logic [NDICE*W-1:0]   throw;
  logic [SW-1:0]        sum;
  logic                 valid;
  logic [7:0]           rolls;

  modport master (
    output button,
    output hold,
    input  throw,
    input  sum,
    input  valid,
    input  rolls
  );

  modport slave (
    input  button,
    input  hold,
    output throw,
    output sum,
    output valid,
    output rolls
  );
endinterface

// File: rtl/dice_roller.sv
// Multi-die odometer dice: die 0 steps while button is high, higher dice step on carry.
// Button release latches the total, pulses valid and counts throws (saturating).
module dice_roller #(
  parameter int unsigned FACES = 6,
  parameter int unsigned NDICE = 2
) (
  input  logic          clk,
  input  logic          rst,
  dice_roller_if.slave  bus
);
  localparam int unsigned W  = $clog2(FACES + 1);
  localparam int unsigned SW = $clog2(NDICE * FACES + 1);

  localparam logic [W-1:0] FaceMax = W'(FACES);
  localparam logic [W-1:0] FaceMin = W'(1);

  logic [W-1:0]  dice_q [NDICE];
  logic [W-1:0]  dice_d [NDICE];
  logic          button_q;
  logic          valid_q;
  logic          valid_d;
  logic [SW-1:0] sum_q;
  logic [SW-1:0] sum_d;
  logic [SW-1:0] total;
  logic [7:0]    rolls_q;
  logic [7:0]    rolls_d;
  logic          release_edge;

  // Odometer step chain. An illegal value is corrected to 1 and breaks the carry;
  // a held die passes the incoming carry straight through.
  always_comb begin : step_chain
    logic carry;
    carry = bus.button;
    for (int unsigned k = 0; k < NDICE; k++) begin
      dice_d[k] = dice_q[k];
      if (dice_q[k] == '0 || dice_q[k] > FaceMax) begin
        dice_d[k] = FaceMin;
        carry     = 1'b0;
      end else if (!bus.hold[k]) begin
        if (carry) begin
          dice_d[k] = (dice_q[k] == FaceMax) ? FaceMin : dice_q[k] + FaceMin;
        end
        carry = carry && (dice_q[k] == FaceMax);
      end
    end
  end

  always_comb begin
    total = '0;
    for (int unsigned k = 0; k < NDICE; k++) begin
      total = total + SW'(dice_q[k]);
    end
  end

  assign release_edge = button_q && !bus.button;

  always_comb begin
    valid_d = release_edge;
    sum_d   = release_edge ? total : sum_q;
    rolls_d = rolls_q;
    if (release_edge && rolls_q != 8'hFF) begin
      rolls_d = rolls_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned k = 0; k < NDICE; k++) begin
        dice_q[k] <= '0;
      end
      button_q <= 1'b0;
      valid_q  <= 1'b0;
      sum_q    <= '0;
      rolls_q  <= '0;
    end else begin
      for (int unsigned k = 0; k < NDICE; k++) begin
        dice_q[k] <= dice_d[k];
      end
      button_q <= bus.button;
      valid_q  <= valid_d;
      sum_q    <= sum_d;
      rolls_q  <= rolls_d;
    end
  end

  always_comb begin
    bus.throw = '0;
    for (int unsigned k = 0; k < NDICE; k++) begin
      bus.throw[k*W +: W] = dice_q[k];
    end
  end

  assign bus.sum   = sum_q;
  assign bus.valid = valid_q;
  assign bus.rolls = rolls_q;

endmodule
